// File: rtl/div_result_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock)
// placed after the divider; a divider error yields an all-F result with err set.
module div_result_bcd #(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   quotient,
    input  logic           div_err,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd,
    output logic           err,
    output logic           state_dbg
);

    localparam int W  = 4*D + N;
    localparam int CW = $clog2(N+1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     work_q, work_d;
    logic [4*D-1:0]   bcd_q, bcd_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     adj;
    logic [W-1:0]     shifted;

    // Add-3 correction is applied per BCD nibble with no carry between nibbles.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < D; i++) begin
            if (work_q[N+4*i +: 4] >= 4'd5) begin
                adj[N+4*i +: 4] = work_q[N+4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[W-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (div_err) begin
                        bcd_d  = '1;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        work_d  = {{(4*D){1'b0}}, quotient};
                        cnt_d   = '0;
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    bcd_d   = shifted[W-1:N];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
